// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the unpack/decode path: field widths,
// special encodings, operand class enum and the unpack FSM state enum.
package fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam int          XEXP_W  = 10;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7fc00000;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUBN = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } unpack_state_e;

  // Quiet/signalling split for a NaN fraction: the MSB of the fraction is the quiet bit.
  function automatic logic frac_is_signalling(input logic quiet_bit);
    return ~quiet_bit;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational FP32 field split and operand classification.
// Shared between the sequential unpacker and the adder's unpack stage.
// Build: no configuration macros.
module fp_classify #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic [EXP_W+MAN_W:0] word,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_field,
  output logic [MAN_W-1:0]     frac,
  output fp_pkg::fp_class_e    cls,
  output logic                 is_zero,
  output logic                 is_subnormal,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic                 is_snan
);
  import fp_pkg::*;

  logic exp_zero_s;
  logic exp_max_s;
  logic frac_zero_s;

  assign sign        = word[EXP_W+MAN_W];
  assign exp_field   = word[EXP_W+MAN_W-1:MAN_W];
  assign frac        = word[MAN_W-1:0];
  assign exp_zero_s  = (exp_field == {EXP_W{1'b0}});
  assign exp_max_s   = (exp_field == {EXP_W{1'b1}});
  assign frac_zero_s = (frac == {MAN_W{1'b0}});

  // Class decode from the exponent/fraction extremes.
  always_comb begin
    cls          = CLS_NORM;
    is_zero      = 1'b0;
    is_subnormal = 1'b0;
    is_inf       = 1'b0;
    is_nan       = 1'b0;
    is_snan      = 1'b0;
    if (exp_zero_s && frac_zero_s) begin
      cls     = CLS_ZERO;
      is_zero = 1'b1;
    end else if (exp_zero_s) begin
      cls          = CLS_SUBN;
      is_subnormal = 1'b1;
    end else if (exp_max_s && frac_zero_s) begin
      cls    = CLS_INF;
      is_inf = 1'b1;
    end else if (exp_max_s) begin
      is_nan  = 1'b1;
      is_snan = frac_is_signalling(frac[MAN_W-1]);
      if (frac[MAN_W-1]) begin
        cls = CLS_QNAN;
      end else begin
        cls = CLS_SNAN;
      end
    end else begin
      cls = CLS_NORM;
    end
  end

endmodule

// File: rtl/fp_unpack_seq.sv
// Multi-cycle FP32 operand decoder. Accepts one packed word over valid/ready,
// classifies it and delivers sign, extended exponent and 24-bit significand.
// Subnormals are normalized one bit per cycle so the result has a leading 1.
// Build macro: FP_UNPACK_DAZ_EN -- when defined, subnormals are flushed to
// signed zero (is_zero and is_subnormal both set) instead of being normalized.
module fp_unpack_seq #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int MAN_W  = fp_pkg::MAN_W,
  parameter int XEXP_W = fp_pkg::XEXP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] fp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign_out,
  output logic [XEXP_W-1:0]    exp_out,
  output logic [MAN_W:0]       mant_out,
  output logic [4:0]           shift_cnt,
  output logic                 is_zero,
  output logic                 is_subnormal,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic                 is_snan
);
  import fp_pkg::*;

  localparam logic [XEXP_W-1:0] XEXP_ONE = {{(XEXP_W-1){1'b0}}, 1'b1};

  // Classifier outputs for the word currently on fp_in.
  logic                c_sign_s;
  logic [EXP_W-1:0]    c_exp_s;
  logic [MAN_W-1:0]    c_frac_s;
  fp_class_e           c_cls_s;
  logic                c_zero_s;
  logic                c_subn_s;
  logic                c_inf_s;
  logic                c_nan_s;
  logic                c_snan_s;

  // Registered state and outputs.
  unpack_state_e       state_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                sign_r;
  logic [XEXP_W-1:0]   exp_r;
  logic [MAN_W:0]      mant_r;
  logic [4:0]          shift_cnt_r;
  logic                is_zero_r;
  logic                is_subnormal_r;
  logic                is_inf_r;
  logic                is_nan_r;
  logic                is_snan_r;

  fp_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_classify (
    .word         (fp_in),
    .sign         (c_sign_s),
    .exp_field    (c_exp_s),
    .frac         (c_frac_s),
    .cls          (c_cls_s),
    .is_zero      (c_zero_s),
    .is_subnormal (c_subn_s),
    .is_inf       (c_inf_s),
    .is_nan       (c_nan_s),
    .is_snan      (c_snan_s)
  );

  // Accept / normalize / deliver FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      sign_r         <= 1'b0;
      exp_r          <= {XEXP_W{1'b0}};
      mant_r         <= {(MAN_W+1){1'b0}};
      shift_cnt_r    <= 5'd0;
      is_zero_r      <= 1'b0;
      is_subnormal_r <= 1'b0;
      is_inf_r       <= 1'b0;
      is_nan_r       <= 1'b0;
      is_snan_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            in_ready_r     <= 1'b0;
            sign_r         <= c_sign_s;
            shift_cnt_r    <= 5'd0;
            is_zero_r      <= c_zero_s;
            is_subnormal_r <= c_subn_s;
            is_inf_r       <= c_inf_s;
            is_nan_r       <= c_nan_s;
            is_snan_r      <= c_snan_s;
            case (c_cls_s)
              CLS_ZERO: begin
                exp_r       <= {XEXP_W{1'b0}};
                mant_r      <= {(MAN_W+1){1'b0}};
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
              end
              CLS_INF: begin
                exp_r       <= {{(XEXP_W-EXP_W){1'b0}}, c_exp_s};
                mant_r      <= {(MAN_W+1){1'b0}};
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
              end
              CLS_QNAN, CLS_SNAN: begin
                exp_r       <= {{(XEXP_W-EXP_W){1'b0}}, c_exp_s};
                mant_r      <= {1'b0, c_frac_s};
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
              end
              CLS_SUBN: begin
`ifdef FP_UNPACK_DAZ_EN
                // Flush to signed zero; is_subnormal keeps the original class visible.
                exp_r       <= {XEXP_W{1'b0}};
                mant_r      <= {(MAN_W+1){1'b0}};
                is_zero_r   <= 1'b1;
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
`else
                // Subnormals share the minimum normal exponent before shifting.
                exp_r       <= XEXP_ONE;
                mant_r      <= {1'b0, c_frac_s};
                state_r     <= ST_SHIFT;
                out_valid_r <= 1'b0;
`endif
              end
              CLS_NORM: begin
                exp_r       <= {{(XEXP_W-EXP_W){1'b0}}, c_exp_s};
                mant_r      <= {1'b1, c_frac_s};
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
              end
              default: begin
                exp_r       <= {{(XEXP_W-EXP_W){1'b0}}, c_exp_s};
                mant_r      <= {1'b1, c_frac_s};
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
              end
            endcase
          end else begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // One bit per cycle; a set bit just below the hidden position is the last shift.
          mant_r      <= {mant_r[MAN_W-1:0], 1'b0};
          exp_r       <= exp_r - XEXP_ONE;
          shift_cnt_r <= shift_cnt_r + 5'd1;
          if (mant_r[MAN_W-1]) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_SHIFT;
            out_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign sign_out     = sign_r;
  assign exp_out      = exp_r;
  assign mant_out     = mant_r;
  assign shift_cnt    = shift_cnt_r;
  assign is_zero      = is_zero_r;
  assign is_subnormal = is_subnormal_r;
  assign is_inf       = is_inf_r;
  assign is_nan       = is_nan_r;
  assign is_snan      = is_snan_r;

endmodule

// File: tb/tb_fp_unpack_seq.sv
// Self-checking bench for fp_unpack_seq: directed plan cases, randomized
// words against an arithmetic reference model, backpressure and reset abort.
module tb_fp_unpack_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [9:0]  exp_out;
  logic [23:0] mant_out;
  logic [4:0]  shift_cnt;
  logic        is_zero;
  logic        is_subnormal;
  logic        is_inf;
  logic        is_nan;
  logic        is_snan;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic [4:0]  shift;
    logic [4:0]  flags;   // {zero, subnormal, inf, nan, snan}
    int          lat;
  } res_t;

  fp_unpack_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fp_in        (fp_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sign_out     (sign_out),
    .exp_out      (exp_out),
    .mant_out     (mant_out),
    .shift_cnt    (shift_cnt),
    .is_zero      (is_zero),
    .is_subnormal (is_subnormal),
    .is_inf       (is_inf),
    .is_nan       (is_nan),
    .is_snan      (is_snan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value-level decode of an FP32 word.
  function automatic res_t model(input logic [31:0] w);
    res_t r;
    int   e;
    int   f;
    int   p;
    int   k;
    e = int'(w[30:23]);
    f = int'(w[22:0]);
    r.sign  = w[31];
    r.shift = 5'd0;
    r.flags = 5'b00000;
    r.lat   = 1;
    if (e == 0 && f == 0) begin
      r.exp = 10'd0; r.mant = 24'd0; r.flags = 5'b10000;
    end else if (e == 255) begin
      r.exp = 10'd255;
      if (f == 0) begin
        r.mant = 24'd0; r.flags = 5'b00100;
      end else begin
        r.mant = 24'(f); r.flags = {3'b000, 1'b1, ~w[22]};
      end
    end else if (e == 0) begin
`ifdef FP_UNPACK_DAZ_EN
      r.exp = 10'd0; r.mant = 24'd0; r.flags = 5'b11000;
`else
      p = 0;
      for (int b = 0; b < 23; b++) if (((f >> b) & 1) == 1) p = b;
      k = 23 - p;
      r.mant  = 24'(f * (1 << k));
      r.exp   = 10'(1 - k);
      r.shift = 5'(k);
      r.lat   = 1 + k;
      r.flags = 5'b01000;
`endif
    end else begin
      r.exp = 10'(e); r.mant = 24'(f + (1 << 23));
    end
    return r;
  endfunction

  task automatic sample(output res_t o);
    o.sign  = sign_out;
    o.exp   = exp_out;
    o.mant  = mant_out;
    o.shift = shift_cnt;
    o.flags = {is_zero, is_subnormal, is_inf, is_nan, is_snan};
    o.lat   = 0;
  endtask

  // Present a word until accepted; time is aligned #1 after a posedge on entry/exit.
  task automatic start_word(input logic [31:0] w);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1;
    fp_in    = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fp_in    = $urandom;
  endtask

  // Count cycles from acceptance until out_valid; flag any in_ready while busy.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fp_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
    checks++;
    if ({sign_out, exp_out, mant_out, shift_cnt, is_zero, is_subnormal, is_inf, is_nan, is_snan} !== 45'd0) begin
      errors++;
      $display("FAIL reset_data: got exp=%h mant=%h shift=%0d want all zero", exp_out, mant_out, shift_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] words [12];
    res_t exp_r;
    res_t got;
    int   lat;
    bit   busy_ok;
    words = '{32'h3F800000, 32'h00000001, 32'h000A0000, 32'h7F800001,
              32'hFF800000, 32'h80000000, 32'h80400000, 32'h7FC00000,
              32'h7F7FFFFF, 32'h00800000, 32'h007FFFFF, 32'h8000F00D};
    foreach (words[i]) begin
      exp_r = model(words[i]);
      start_word(words[i]);
      wait_valid(lat, busy_ok);
      sample(got);
      checks++;
      if ({got.sign, got.exp, got.mant, got.shift, got.flags} !==
          {exp_r.sign, exp_r.exp, exp_r.mant, exp_r.shift, exp_r.flags}) begin
        errors++;
        $display("FAIL directed_data %h: got s=%b e=%h m=%h sh=%0d fl=%b want s=%b e=%h m=%h sh=%0d fl=%b",
                 words[i], got.sign, got.exp, got.mant, got.shift, got.flags,
                 exp_r.sign, exp_r.exp, exp_r.mant, exp_r.shift, exp_r.flags);
      end
      checks++;
      if (lat !== exp_r.lat || !busy_ok) begin
        errors++;
        $display("FAIL directed_lat %h: got lat=%0d busy_ok=%b want lat=%0d busy_ok=1",
                 words[i], lat, busy_ok, exp_r.lat);
      end
      if (words[i] == 32'h3F800000) begin
        checks++;
        if (got.exp !== 10'd127 || got.mant !== 24'h800000 || got.flags !== 5'b00000 || lat !== 1) begin
          errors++;
          $display("FAIL one_const: got e=%h m=%h fl=%b lat=%0d want e=07f m=800000 fl=00000 lat=1",
                   got.exp, got.mant, got.flags, lat);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_release %h: got ready=%b valid=%b want ready=1 valid=0",
                 words[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [22:0] f;
    logic [7:0]  e;
    res_t exp_r;
    res_t got;
    int   lat;
    bit   busy_ok;
    int   bad;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      f = 23'($urandom);
      case ($urandom_range(0, 4))
        0: e = 8'($urandom_range(1, 254));
        1: begin e = 8'd0; f = f >> $urandom_range(0, 22); if (f == 23'd0) f = 23'd1; end
        2: begin e = 8'd0; f = 23'd0; end
        3: begin e = 8'hFF; f = 23'd0; end
        default: begin e = 8'hFF; if (f == 23'd0) f = 23'd5; end
      endcase
      w = {1'($urandom), e, f};
      exp_r = model(w);
      start_word(w);
      wait_valid(lat, busy_ok);
      sample(got);
      if ({got.sign, got.exp, got.mant, got.shift, got.flags} !==
          {exp_r.sign, exp_r.exp, exp_r.mant, exp_r.shift, exp_r.flags} ||
          lat !== exp_r.lat || !busy_ok) begin
        bad++;
        $display("FAIL random %h: got e=%h m=%h sh=%0d fl=%b lat=%0d want e=%h m=%h sh=%0d fl=%b lat=%0d",
                 w, got.exp, got.mant, got.shift, got.flags, lat,
                 exp_r.exp, exp_r.mant, exp_r.shift, exp_r.flags, exp_r.lat);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_summary: got %0d bad words want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    res_t exp_r;
    res_t first;
    res_t now;
    int   lat;
    bit   busy_ok;
    bit   stable;
    exp_r = model(32'h14300000);
    out_ready = 1'b0;
    start_word(32'h14300000);
    wait_valid(lat, busy_ok);
    sample(first);
    checks++;
    if ({first.sign, first.exp, first.mant, first.flags} !== {exp_r.sign, exp_r.exp, exp_r.mant, exp_r.flags}) begin
      errors++;
      $display("FAIL bp_data: got e=%h m=%h want e=%h m=%h", first.exp, first.mant, exp_r.exp, exp_r.mant);
    end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      sample(now);
      if ({now.sign, now.exp, now.mant, now.shift, now.flags} !== {first.sign, first.exp, first.mant, first.shift, first.flags} ||
          in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: got unstable outputs or ready=%b valid=%b want stable, ready=0 valid=1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    res_t exp_r;
    res_t got;
    int   lat;
    bit   busy_ok;
    start_word(32'h00000001);
    repeat (4) begin @(posedge clk); #1; end
`ifndef FP_UNPACK_DAZ_EN
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || shift_cnt !== 5'd4) begin
      errors++;
      $display("FAIL mid_shift: got ready=%b valid=%b sh=%0d want ready=0 valid=0 sh=4", in_ready, out_valid, shift_cnt);
    end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {sign_out, exp_out, mant_out, shift_cnt, is_zero, is_subnormal, is_inf, is_nan, is_snan} !== 45'd0) begin
      errors++;
      $display("FAIL abort_reset: got ready=%b valid=%b e=%h m=%h sh=%0d want idle zeros",
               in_ready, out_valid, exp_out, mant_out, shift_cnt);
    end
    exp_r = model(32'hC0490FDB);
    start_word(32'hC0490FDB);
    wait_valid(lat, busy_ok);
    sample(got);
    checks++;
    if ({got.sign, got.exp, got.mant, got.flags} !== {exp_r.sign, exp_r.exp, exp_r.mant, exp_r.flags} || lat !== 1) begin
      errors++;
      $display("FAIL after_reset: got s=%b e=%h m=%h lat=%0d want s=%b e=%h m=%h lat=1",
               got.sign, got.exp, got.mant, lat, exp_r.sign, exp_r.exp, exp_r.mant);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_unpack_seq.md
Name: fp_unpack_seq

Overview:
- Multi-cycle FP32 operand decoder. It is the decode-side counterpart of the adder's normalize/round/pack path.
- Accepts a packed single-precision word over a valid/ready handshake.
- Classifies the word and splits it into sign, extended exponent and 24-bit significand.
- Normalizes subnormals by an iterative one-bit-per-cycle left shift, so downstream FPU stages always see a leading 1.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width
- XEXP_W, 10, signed extended exponent output width (must hold -22..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word
- fp_in  in  32  packed FP32 operand
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts result
- sign_out  out  1  sign bit
- exp_out  out  XEXP_W  signed exponent; value = mant_out * 2^(exp_out-127-23)
- mant_out  out  24  significand incl. hidden bit
- shift_cnt  out  5  normalization shifts applied
- is_zero, is_subnormal, is_inf, is_nan, is_snan  out  1 each  class flags

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, all data outputs and flags 0. A reset asserted mid-SHIFT or in DONE aborts the word; the next cycle shows IDLE outputs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture fp_in and decode E=fp_in[30:23], F=fp_in[22:0]:
  - Normal (0<E<255): exp=E, mant={1,F}, go DONE.
  - Zero (E=0, F=0): exp=0, mant=0, is_zero=1, go DONE.
  - Inf (E=255, F=0): exp=255, mant=0, is_inf=1, go DONE.
  - NaN (E=255, F!=0): exp=255, mant={0,F}, is_nan=1, is_snan=~F[22], go DONE.
  - Subnormal (E=0, F!=0): exp=1, mant={0,F}, is_subnormal=1, shift_cnt=0, go SHIFT.
- SHIFT: in_ready=0, out_valid=0. Each cycle: mant<<=1, exp-=1, shift_cnt+=1. If the pre-shift mant[22]=1, go DONE.
- SHIFT count: for k = leading zeros of {0,F} (1..23), exactly k SHIFT edges occur. Final exp = 1-k, mant[23]=1.
- Latency, acceptance edge to out_valid: 1 cycle for normal/zero/inf/NaN; 1+k cycles for subnormals.
- DONE: out_valid=1, in_ready=0. All outputs hold stable until out_ready. On out_valid&&out_ready, go IDLE and drop out_valid the next cycle.
- Throughput: one word per (latency+1) cycles minimum. There is no overlap of accept and deliver.
- in_valid in SHIFT/DONE is ignored, since in_ready=0. Upstream must hold the word.
- Width rules:
  - exp arithmetic is XEXP_W-bit two's complement; no wrap is possible within the range -22..255.
  - shift_cnt saturates only by construction (max 23).
  - Sign is passed through for every class, including zero and NaN.

Optional Feature:
- Macro: FP_UNPACK_DAZ_EN (denormals-are-zero).
- Defined: subnormal inputs skip SHIFT. They go to DONE in 1 cycle with exp=0, mant=0, shift_cnt=0, is_zero=1, is_subnormal=1, and the sign preserved.
- Undefined: full iterative normalization as above.

Decomposition:
- Package fp_pkg holds:
  - FP32 constants: EXP_W, MAN_W, BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7fc00000.
  - Class enum: ZERO, SUBN, NORM, INF, QNAN, SNAN.
  - FSM state enum.
- One natural combinational sub-module, fp_classify: field split plus class flags. It is reusable by the adder's unpack stage. The shift FSM stays in fp_unpack_seq.

Test Plan:
- fp_in=0x3F800000, out_ready=1 -> out_valid 1 cycle after accept; sign 0, exp 127, mant 0x800000, all flags 0.
- fp_in=0x00000001 -> out_valid 24 cycles after accept; exp=-22 (10'h3EA), mant 0x800000, shift_cnt 23, is_subnormal=1.
- fp_in=0x000A0000 -> 5-cycle latency; exp=-3, mant 0xA00000, shift_cnt 4.
- Special classes:
  - fp_in=0x7F800001 -> is_nan=1, is_snan=1, exp 255, mant 0x000001.
  - 0xFF800000 -> is_inf=1, sign 1.
  - 0x80000000 -> is_zero=1, sign 1.
- Backpressure: 0x14300000 with out_ready low 10 cycles -> outputs stable, in_ready=0 throughout. Then out_ready=1 -> handshake, next cycle in_ready=1, out_valid=0.
- Reset during SHIFT of 0x00000001 (cycle 5) -> next cycle IDLE, out_valid=0, in_ready=1, outputs 0. With FP_UNPACK_DAZ_EN, 0x00000001 -> 1-cycle result, is_zero=1, is_subnormal=1.
